// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int DEFAULT_GAP_CYCLES     = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority selector: returns the first set request found when
// scanning ptr, ptr+1, ... wrapping modulo NUM_REQ.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  int pos;

  // Scan from lowest priority to highest so the highest-priority hit is written last
  always_comb begin
    found = |req;
    index = '0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) index = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// One byte per grant; tx_en_sig stays high until the transmitter pulses done,
// followed by GAP_CYCLES idle clocks before the next arbitration.
// Optional feature: define UART_TX_TIMEOUT_EN to abort a frame that has waited
// TIMEOUT_CYCLES clocks in SEND without tx_done_sig (adds the timeout_err port).
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [8*NUM_REQ-1:0]             req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             tx_en_sig,
  output logic [7:0]                       tx_data,
  input  logic                             tx_done_sig,
  output logic                             busy,
  output logic [idx_width(NUM_REQ)-1:0]    grant_id
`ifdef UART_TX_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int GAP_W = idx_width(GAP_CYCLES);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter value");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               end_frame;

`ifdef UART_TX_TIMEOUT_EN
  localparam int TO_W = idx_width(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif

  assign req_ready = req_ready_q;
  assign tx_en_sig = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

  // Priority restarts just after whoever was served last
  assign next_ptr = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next-state and next-output computation for the IDLE -> SEND -> GAP cycle
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    req_ready_d = '0;
    tx_en_d     = tx_en_q;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    gap_cnt_d   = gap_cnt_q;
    end_frame   = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_SEND;
          grant_id_d  = pick_idx;
          req_ready_d = NUM_REQ'(1) << pick_idx;
          tx_en_d     = 1'b1;
          tx_data_d   = req_data[8*pick_idx +: 8];
          busy_d      = 1'b1;
`ifdef UART_TX_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ST_SEND: begin
        if (tx_done_sig) begin
          end_frame = 1'b1;
        end
`ifdef UART_TX_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          end_frame     = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_frame) begin
      tx_en_d   = 1'b0;
      ptr_d     = next_ptr;
      gap_cnt_d = '0;
      if (GAP_CYCLES == 0) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = ST_GAP;
      end
    end
  end

  // Single register stage for FSM state, pointer, data latch, counters and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= '0;
`ifdef UART_TX_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef UART_TX_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte sources and a transmitter
// stand-in drive the DUT; a transaction-level model predicts every output.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int GAP      = 2;
  localparam int DONE_LAT = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_en_sig;
  logic [7:0]     tx_data;
  logic           tx_done_sig;
  logic           busy;
  logic [1:0]     grant_id;
`ifdef UART_TX_TIMEOUT_EN
  logic           timeout_err;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_en_sig   (tx_en_sig),
    .tx_data     (tx_data),
    .tx_done_sig (tx_done_sig),
    .busy        (busy),
    .grant_id    (grant_id)
`ifdef UART_TX_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // Transaction-level prediction: a frame is in flight or not, a gap has N clocks left, ptr is an integer
  int         m_ptr      = 0;
  bit         m_inflight = 1'b0;
  int         m_gap_left = 0;
  logic       m_en       = 1'b0;
  logic       m_busy     = 1'b0;
  logic [7:0] m_data     = 8'h00;
  logic [N-1:0] m_ready  = '0;
  int         m_gid      = 0;

  // Advance the model one clock using the inputs the DUT also samples
  always @(posedge clk) begin : model
    int ptr, gl, w, gid;
    bit inf;
    logic en, bz;
    logic [7:0] d;
    logic [N-1:0] rdy;
    ptr = m_ptr; gl = m_gap_left; inf = m_inflight; en = m_en;
    bz = m_busy; d = m_data; gid = m_gid; rdy = '0; w = -1;
    if (rst) begin
      ptr = 0; gl = 0; inf = 1'b0; en = 1'b0; bz = 1'b0; d = 8'h00; gid = 0;
    end else if (inf) begin
      if (tx_done_sig) begin
        inf = 1'b0; en = 1'b0; ptr = (gid + 1) % N; gl = GAP; bz = (GAP > 0);
      end
    end else if (gl > 0) begin
      gl = gl - 1;
      if (gl == 0) bz = 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
      if (w >= 0) begin
        inf = 1'b1; en = 1'b1; bz = 1'b1; gid = w; d = req_data[8*w +: 8]; rdy[w] = 1'b1;
      end
    end
    m_ptr <= ptr; m_gap_left <= gl; m_inflight <= inf; m_en <= en;
    m_busy <= bz; m_data <= d; m_gid <= gid; m_ready <= rdy;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         src_cnt [N];
  logic [7:0] src_data [N];
  bit         auto_done = 1'b1;
  bit         manual_done = 1'b0;
  int         en_cnt = 0;
  int         gap_cyc = 0;
  int         grant_log [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock per iteration: compare against the model, then play sources and transmitter
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checkOutput("tx_en_sig", 32'(tx_en_sig), 32'(m_en));
      checkOutput("busy",      32'(busy),      32'(m_busy));
      checkOutput("tx_data",   32'(tx_data),   32'(m_data));
      checkOutput("req_ready", 32'(req_ready), 32'(m_ready));
      checkOutput("grant_id",  32'(grant_id),  32'(m_gid));
`ifdef UART_TX_TIMEOUT_EN
      checkOutput("timeout_err", 32'(timeout_err), 32'd0);
`endif
      if (req_ready != '0) grant_log.push_back(int'(grant_id));
      if (busy && !tx_en_sig) gap_cyc++;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && src_cnt[i] > 0) begin
          src_cnt[i]--;
          src_data[i] = src_data[i] + 8'h11;
        end
      en_cnt = tx_en_sig ? en_cnt + 1 : 0;
      for (int i = 0; i < N; i++) begin
        req_valid[i]       = (src_cnt[i] > 0);
        req_data[8*i +: 8] = src_data[i];
      end
      tx_done_sig = manual_done | (auto_done && en_cnt == DONE_LAT);
    end
  endtask

  task automatic doReset();
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    grant_log.delete();
    gap_cyc = 0;
  endtask

  task automatic waitGrants(input int n, input int bound, input string name);
    int c = 0;
    while (grant_log.size() < n && c < bound) begin
      applyStimulus(1);
      c++;
    end
    checkOutput(name, 32'(grant_log.size()), 32'(n));
  endtask

  task automatic waitEnLow(input int bound, input string name);
    int c = 0;
    while (tx_en_sig && c < bound) begin
      applyStimulus(1);
      c++;
    end
    checkOutput(name, 32'(tx_en_sig), 32'd0);
  endtask

  task automatic checkOrder(input string name, input int k, input int exp);
    int act;
    act = (k < grant_log.size()) ? grant_log[k] : -1;
    checkOutput(name, 32'(act), 32'(exp));
  endtask

  initial begin
    int en_len;
    rst = 1'b1; req_valid = '0; req_data = '0; tx_done_sig = 1'b0;
    for (int i = 0; i < N; i++) begin src_cnt[i] = 0; src_data[i] = 8'h00; end

    // Reset state
    doReset();
    checkOutput("reset tx_en_sig", 32'(tx_en_sig), 32'd0);
    checkOutput("reset busy",      32'(busy),      32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset grant_id",  32'(grant_id),  32'd0);
    checkOutput("reset tx_data",   32'(tx_data),   32'd0);

    // Single byte from requester 0
    src_cnt[0] = 1; src_data[0] = 8'hA5;
    applyStimulus(2);
    checkOutput("t1 req_ready", 32'(req_ready), 32'h1);
    checkOutput("t1 tx_data",   32'(tx_data),   32'hA5);
    checkOutput("t1 tx_en_sig", 32'(tx_en_sig), 32'd1);
    en_len = 1;
    while (tx_en_sig && en_len < 60) begin
      applyStimulus(1);
      if (tx_en_sig) en_len++;
    end
    checkOutput("t1 en length", 32'(en_len), 32'(DONE_LAT));
    checkOutput("t1 gap busy0", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("t1 gap busy1", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("t1 idle busy", 32'(busy), 32'd0);

    // All four requesters busy: strict rotation with gaps between frames
    doReset();
    src_cnt[0] = 2; src_data[0] = 8'h30;
    src_cnt[1] = 2; src_data[1] = 8'h41;
    src_cnt[2] = 2; src_data[2] = 8'h52;
    src_cnt[3] = 2; src_data[3] = 8'h63;
    waitGrants(5, 300, "t2 grant count");
    checkOrder("t2 order0", 0, 0);
    checkOrder("t2 order1", 1, 1);
    checkOrder("t2 order2", 2, 2);
    checkOrder("t2 order3", 3, 3);
    checkOrder("t2 order4", 4, 0);
    checkOutput("t2 gap cycles", 32'(gap_cyc), 32'(4 * GAP));

    // Persistent requester 2 must yield to requester 1
    doReset();
    src_cnt[2] = 3; src_data[2] = 8'h22;
    waitGrants(1, 10, "t3 first grant");
    src_cnt[1] = 1; src_data[1] = 8'h11;
    waitGrants(3, 200, "t3 grant count");
    checkOrder("t3 order0", 0, 2);
    checkOrder("t3 order1", 1, 1);
    checkOrder("t3 order2", 2, 2);

    // Reset mid-SEND drops the frame and restarts priority at requester 0
    doReset();
    src_cnt[3] = 1; src_data[3] = 8'h3C;
    waitGrants(1, 10, "t4 first grant");
    applyStimulus(5);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("t4 rst tx_en_sig", 32'(tx_en_sig), 32'd0);
    checkOutput("t4 rst busy",      32'(busy),      32'd0);
    src_cnt[0] = 1; src_data[0] = 8'h0F;
    src_cnt[3] = 1; src_data[3] = 8'hF3;
    grant_log.delete();
    waitGrants(1, 10, "t4 regrant");
    checkOrder("t4 after reset", 0, 0);

    // tx_done_sig outside SEND is ignored
    waitGrants(2, 100, "t5 drain");
    waitEnLow(40, "t5 drain en");
    applyStimulus(3);
    manual_done = 1'b1;
    applyStimulus(1);
    manual_done = 1'b0;
    applyStimulus(1);
    checkOutput("t5 idle tx_en_sig", 32'(tx_en_sig), 32'd0);
    checkOutput("t5 idle busy",      32'(busy),      32'd0);
    checkOutput("t5 idle req_ready", 32'(req_ready), 32'd0);
    src_cnt[1] = 1; src_data[1] = 8'h5A;
    waitGrants(3, 10, "t5 grant");
    waitEnLow(40, "t5 frame end");
    manual_done = 1'b1;
    applyStimulus(1);
    checkOutput("t5 gap busy", 32'(busy), 32'd1);
    manual_done = 1'b0;
    applyStimulus(1);
    checkOutput("t5 post-gap busy",      32'(busy),      32'd0);
    checkOutput("t5 post-gap tx_en_sig", 32'(tx_en_sig), 32'd0);
    applyStimulus(3);
    checkOutput("t5 no stray ready", 32'(grant_log.size()), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Last-resort guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
